// File: rtl/cpu_pkg.sv
// Shared types and constants for the integer datapath front end.
package cpu_pkg;

    // Fetch sequencer state encoding (2-bit).
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_REQ   = 2'b01,
        ST_DONE  = 2'b10,
        ST_FAULT = 2'b11
    } fetch_state_t;

    // Next-PC source select.
    localparam logic [1:0] PC_SEL_SEQ = 2'b00;
    localparam logic [1:0] PC_SEL_BR  = 2'b01;
    localparam logic [1:0] PC_SEL_JMP = 2'b10;
    localparam logic [1:0] PC_SEL_JR  = 2'b11;

    // Default PC after reset; the top module exposes it as its RESET_PC parameter.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Sign-extend a 16-bit immediate to 32 bits.
    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory request/acknowledge port.
interface instruction_fetch_unit_if;
    logic        im_req;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic        im_ack;

    // Fetch unit side: issues requests, receives data.
    modport master (
        output im_req,
        output im_addr,
        input  im_rdata,
        input  im_ack
    );

    // Memory side: serves requests.
    modport slave (
        input  im_req,
        input  im_addr,
        output im_rdata,
        output im_ack
    );
endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection and word-alignment check.
module pc_next_calc
    import cpu_pkg::*;
(
    input  logic [1:0]  pc_sel,
    input  logic [31:0] pc,
    input  logic [31:0] se_16,
    input  logic [25:0] jidx,
    input  logic [31:0] pc_jr,
    output logic [31:0] target,
    output logic        misaligned
);

    // Select the target; the branch offset is relative to the PC that already
    // points past the branch instruction.
    always_comb begin
        target = pc + 32'd4;
        unique case (pc_sel)
            PC_SEL_SEQ: target = pc + 32'd4;
            PC_SEL_BR:  target = pc + {se_16[29:0], 2'b00};
            PC_SEL_JMP: target = {pc[31:28], jidx, 2'b00};
            PC_SEL_JR:  target = pc_jr;
            default:    target = pc + 32'd4;
        endcase
    end

    assign misaligned = (target[1:0] != 2'b00);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC/IR registers, fetch sequencer with ack timeout,
// and next-PC update driven by the control unit.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | waiting for fetch_req / pc_ld after reset
//  ST_REQ   | im_req high, waiting for im_ack (timer counts wait cycles)
//  ST_DONE  | IR holds a freshly fetched word (ir_valid high)
//  ST_FAULT | timeout or misaligned PC load; inputs ignored until reset
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC_DEFAULT,
    parameter int          TIMEOUT  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fetch_req,
    input  logic                       pc_ld,
    input  logic [1:0]                 pc_sel,
    input  logic [31:0]                pc_jr,
    instruction_fetch_unit_if.master   im,
    output logic [31:0]                pc_out,
    output logic [31:0]                ir_out,
    output logic [31:0]                se_16,
    output logic                       ir_valid,
    output logic                       busy,
    output logic                       fault
);

    localparam int                 TIMER_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT - 1);

    fetch_state_t       state, state_nxt;
    logic [31:0]        pc_q;
    logic [31:0]        ir_q;
    logic [31:0]        im_addr_q;
    logic               im_req_q;
    logic [TIMER_W-1:0] timer_q;

    logic [31:0]        pc_target;
    logic               pc_misaligned;

    logic               ld_ok;
    logic               start;
    logic               ack_take;
    logic               tmo;

    pc_next_calc u_pc_next_calc (
        .pc_sel     (pc_sel),
        .pc         (pc_q),
        .se_16      (se_16),
        .jidx       (ir_q[25:0]),
        .pc_jr      (pc_jr),
        .target     (pc_target),
        .misaligned (pc_misaligned)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-cycle action strobes.
    always_comb begin
        state_nxt = state;
        ld_ok     = 1'b0;
        start     = 1'b0;
        ack_take  = 1'b0;
        tmo       = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (pc_ld && pc_misaligned) begin
                    // A bad target also cancels any fetch requested alongside it.
                    state_nxt = ST_FAULT;
                end else begin
                    ld_ok = pc_ld;
                    if (fetch_req) begin
                        start     = 1'b1;
                        state_nxt = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (im_req_q && im.im_ack) begin
                    ack_take  = 1'b1;
                    state_nxt = ST_DONE;
                end else if (timer_q == TIMER_MAX) begin
                    tmo       = 1'b1;
                    state_nxt = ST_FAULT;
                end
            end
            ST_FAULT: begin
                state_nxt = ST_FAULT;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // PC and IR registers: a load takes priority, fetch completion advances PC.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q <= RESET_PC;
            ir_q <= 32'h0;
        end else begin
            if (ld_ok) begin
                pc_q <= pc_target;
            end else if (ack_take) begin
                pc_q <= pc_q + 32'd4;
            end
            if (ack_take) begin
                ir_q <= im.im_rdata;
            end
        end
    end

    // Memory request, captured address and wait timer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            im_req_q  <= 1'b0;
            im_addr_q <= 32'h0;
            timer_q   <= '0;
        end else begin
            if (start) begin
                // Same-cycle pc_ld: fetch from the freshly loaded PC.
                im_addr_q <= ld_ok ? pc_target : pc_q;
                im_req_q  <= 1'b1;
                timer_q   <= '0;
            end else if (ack_take || tmo) begin
                im_req_q  <= 1'b0;
            end else if (state == ST_REQ) begin
                timer_q   <= timer_q + TIMER_W'(1);
            end
        end
    end

    assign im.im_req  = im_req_q;
    assign im.im_addr = im_addr_q;

    assign pc_out   = pc_q;
    assign ir_out   = ir_q;
    assign se_16    = sign_ext16(ir_q[15:0]);
    assign ir_valid = (state == ST_DONE);
    assign busy     = (state == ST_REQ);
    assign fault    = (state == ST_FAULT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: cycle table plus timeout and
// mid-fetch reset sequences.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset;
    logic        fetch_req;
    logic        pc_ld;
    logic [1:0]  pc_sel;
    logic [31:0] pc_jr;
    logic [31:0] pc_out;
    logic [31:0] ir_out;
    logic [31:0] se_16;
    logic        ir_valid;
    logic        busy;
    logic        fault;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch_unit_if im_bus ();

    instruction_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .fetch_req (fetch_req),
        .pc_ld     (pc_ld),
        .pc_sel    (pc_sel),
        .pc_jr     (pc_jr),
        .im        (im_bus),
        .pc_out    (pc_out),
        .ir_out    (ir_out),
        .se_16     (se_16),
        .ir_valid  (ir_valid),
        .busy      (busy),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst_n;
        logic        fetch;
        logic        ld;
        logic [1:0]  sel;
        logic [31:0] jr;
        logic        ack;
        logic [31:0] rdata;
        logic [31:0] pc;
        logic [31:0] ir;
        logic        req;
        logic [31:0] addr;
        logic        bsy;
        logic        vld;
        logic        flt;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic rst_n, input logic fetch, input logic ld, input logic [1:0] sel,
        input logic [31:0] jr, input logic ack, input logic [31:0] rdata,
        input logic [31:0] pc, input logic [31:0] ir, input logic req,
        input logic [31:0] addr, input logic bsy, input logic vld, input logic flt);
        vec_t v;
        v.rst_n = rst_n; v.fetch = fetch; v.ld = ld; v.sel = sel; v.jr = jr;
        v.ack = ack; v.rdata = rdata; v.pc = pc; v.ir = ir; v.req = req;
        v.addr = addr; v.bsy = bsy; v.vld = vld; v.flt = flt;
        return v;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_req = 1'b0;
        pc_ld     = 1'b0;
        pc_sel    = 2'b00;
        pc_jr     = 32'h0;
        im_bus.im_ack   = 1'b0;
        im_bus.im_rdata = 32'h0;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();

        //              rst fet ld sel jr            ack rdata          pc            ir            req addr          bsy vld flt
        vecs[0]  = mk(0, 0, 0, 2'd0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        0, 32'h0,        0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 2'd0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        0, 32'h0,        0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 2'd0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        0, 32'h0,        0, 0, 0);
        vecs[3]  = mk(1, 1, 0, 2'd0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        1, 32'h0,        1, 0, 0);
        vecs[4]  = mk(1, 0, 0, 2'd0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        1, 32'h0,        1, 0, 0);
        vecs[5]  = mk(1, 0, 0, 2'd0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        1, 32'h0,        1, 0, 0);
        vecs[6]  = mk(1, 0, 0, 2'd0, 32'h0,        1, 32'h2002_0005, 32'h4,       32'h2002_0005, 0, 32'h0,       0, 1, 0);
        vecs[7]  = mk(1, 1, 0, 2'd0, 32'h0,        0, 32'h0,        32'h4,        32'h2002_0005, 1, 32'h4,       1, 0, 0);
        vecs[8]  = mk(1, 0, 0, 2'd0, 32'h0,        1, 32'h1000_FFFE, 32'h8,       32'h1000_FFFE, 0, 32'h4,       0, 1, 0);
        vecs[9]  = mk(1, 0, 1, 2'd1, 32'h0,        0, 32'h0,        32'h0,        32'h1000_FFFE, 0, 32'h4,       0, 1, 0);
        vecs[10] = mk(1, 1, 0, 2'd0, 32'h0,        0, 32'h0,        32'h0,        32'h1000_FFFE, 1, 32'h0,       1, 0, 0);
        vecs[11] = mk(1, 0, 0, 2'd0, 32'h0,        1, 32'h0800_0010, 32'h4,       32'h0800_0010, 0, 32'h0,       0, 1, 0);
        vecs[12] = mk(1, 0, 1, 2'd2, 32'h0,        0, 32'h0,        32'h40,       32'h0800_0010, 0, 32'h0,       0, 1, 0);
        vecs[13] = mk(1, 0, 1, 2'd0, 32'h0,        0, 32'h0,        32'h44,       32'h0800_0010, 0, 32'h0,       0, 1, 0);
        vecs[14] = mk(1, 1, 1, 2'd3, 32'h100,      0, 32'h0,        32'h100,      32'h0800_0010, 1, 32'h100,     1, 0, 0);
        vecs[15] = mk(1, 0, 1, 2'd3, 32'h200,      1, 32'h1234_8000, 32'h104,     32'h1234_8000, 0, 32'h100,     0, 1, 0);
        vecs[16] = mk(1, 0, 1, 2'd3, 32'h102,      0, 32'h0,        32'h104,      32'h1234_8000, 0, 32'h100,     0, 0, 1);
        vecs[17] = mk(1, 1, 0, 2'd0, 32'h0,        0, 32'h0,        32'h104,      32'h1234_8000, 0, 32'h100,     0, 0, 1);
        vecs[18] = mk(1, 0, 1, 2'd0, 32'h0,        0, 32'h0,        32'h104,      32'h1234_8000, 0, 32'h100,     0, 0, 1);
        vecs[19] = mk(0, 0, 0, 2'd0, 32'h0,        0, 32'h0,        32'h0,        32'h0,        0, 32'h0,        0, 0, 0);
        vecs[20] = mk(1, 1, 1, 2'd3, 32'hFFFF_FFFC, 0, 32'h0,       32'hFFFF_FFFC, 32'h0,       1, 32'hFFFF_FFFC, 1, 0, 0);
        vecs[21] = mk(1, 0, 0, 2'd0, 32'h0,        1, 32'hDEAD_BEEF, 32'h0,       32'hDEAD_BEEF, 0, 32'hFFFF_FFFC, 0, 1, 0);
        vecs[22] = mk(1, 0, 0, 2'd0, 32'h0,        1, 32'h1111_1111, 32'h0,       32'hDEAD_BEEF, 0, 32'hFFFF_FFFC, 0, 1, 0);

        for (int i = 0; i < NV; i++) begin
            reset           = vecs[i].rst_n;
            fetch_req       = vecs[i].fetch;
            pc_ld           = vecs[i].ld;
            pc_sel          = vecs[i].sel;
            pc_jr           = vecs[i].jr;
            im_bus.im_ack   = vecs[i].ack;
            im_bus.im_rdata = vecs[i].rdata;
            tick();
            chk32($sformatf("v%0d pc_out", i), pc_out, vecs[i].pc);
            chk32($sformatf("v%0d ir_out", i), ir_out, vecs[i].ir);
            chk32($sformatf("v%0d se_16", i), se_16,
                  {{16{vecs[i].ir[15]}}, vecs[i].ir[15:0]});
            chk1 ($sformatf("v%0d im_req", i), im_bus.im_req, vecs[i].req);
            chk32($sformatf("v%0d im_addr", i), im_bus.im_addr, vecs[i].addr);
            chk1 ($sformatf("v%0d busy", i), busy, vecs[i].bsy);
            chk1 ($sformatf("v%0d ir_valid", i), ir_valid, vecs[i].vld);
            chk1 ($sformatf("v%0d fault", i), fault, vecs[i].flt);
        end

        // Timeout: request never acknowledged, then a late ack must be ignored.
        idle_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        begin
            int cnt;
            cnt = 0;
            for (int i = 0; i < 40; i++) begin
                if (!im_bus.im_req) break;
                cnt++;
                tick();
            end
            chk32("tmo req_cycles", 32'(cnt), 32'd16);
        end
        chk1("tmo im_req", im_bus.im_req, 1'b0);
        chk1("tmo fault", fault, 1'b1);
        chk1("tmo busy", busy, 1'b0);
        im_bus.im_ack   = 1'b1;
        im_bus.im_rdata = 32'hCAFE_F00D;
        tick();
        idle_inputs();
        chk32("tmo late_ack ir", ir_out, 32'h0);
        chk32("tmo late_ack pc", pc_out, 32'h0);
        chk1("tmo late_ack fault", fault, 1'b1);

        // Reset during the second REQ cycle with a same-cycle ack.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        pc_ld = 1'b1;
        pc_sel = 2'b11;
        pc_jr = 32'h0000_0080;
        fetch_req = 1'b1;
        tick();
        idle_inputs();
        chk32("rst_mid pc_loaded", pc_out, 32'h80);
        chk32("rst_mid addr", im_bus.im_addr, 32'h80);
        tick();
        chk1("rst_mid busy_2nd", busy, 1'b1);
        reset = 1'b0;
        im_bus.im_ack   = 1'b1;
        im_bus.im_rdata = 32'h55AA_55AA;
        tick();
        reset = 1'b1;
        idle_inputs();
        chk32("rst_mid pc", pc_out, 32'h0);
        chk32("rst_mid ir", ir_out, 32'h0);
        chk1("rst_mid im_req", im_bus.im_req, 1'b0);
        chk1("rst_mid busy", busy, 1'b0);
        chk1("rst_mid valid", ir_valid, 1'b0);
        chk1("rst_mid fault", fault, 1'b0);
        tick();
        chk32("rst_mid idle_ir", ir_out, 32'h0);
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk1("rst_mid refetch_req", im_bus.im_req, 1'b1);
        chk32("rst_mid refetch_addr", im_bus.im_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
